// File: rtl/vga_text_renderer.sv
// vga_text_renderer: 640x480@60 VGA text-mode requester for an 8x16 font ROM with an 80x30 character buffer.
// Optional blinking underline cursor is enabled with the CURSOR_EN macro.
module vga_text_renderer #(
   parameter logic [11:0] FG_COLOR = 12'hFFF,
   parameter logic [11:0] BG_COLOR = 12'h000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [11:0] wr_addr,
   input  logic [6:0]  wr_data,
   input  logic [6:0]  cursor_col,
   input  logic [4:0]  cursor_row,
   output logic [6:0]  font_ascii,
   output logic [3:0]  font_row,
   output logic [2:0]  font_col,
   input  logic        font_pixel,
   output logic [11:0] rgb,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start
);
   logic [9:0]  h_q, h_d, v_q, v_d;
   logic [6:0]  mem [0:2399];
   logic [11:0] rd_addr;
   logic [6:0]  ch_q;
   logic [2:0]  col1_q;
   logic [3:0]  row1_q, row2_q;
   logic        vis0, hs0, vs0, fs0;
   logic        vis1_q, hs1_q, vs1_q, fs1_q, vis2_q, hs2_q, vs2_q, fs2_q;
   logic [11:0] rgb_q, rgb_d;
   logic        hs_q, vs_q, fs_q, cur;
   always_comb begin
      h_d = (h_q == 10'd799) ? 10'd0 : h_q + 10'd1;
      v_d = (h_q != 10'd799) ? v_q : (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
      rd_addr = {1'b0, v_q[8:4], 6'b0} + {3'b0, v_q[8:4], 4'b0} + {5'b0, h_q[9:3]};
      vis0 = (h_q < 10'd640) && (v_q < 10'd480);
      hs0 = !((h_q >= 10'd656) && (h_q <= 10'd751));
      vs0 = !((v_q >= 10'd490) && (v_q <= 10'd491));
      fs0 = (h_q == 10'd0) && (v_q == 10'd0);
      rgb_d = !vis2_q ? 12'h000 : (font_pixel || cur) ? FG_COLOR : BG_COLOR;
   end
   // Blanking rows past text row 29 form addresses beyond the buffer; redirect them to cell 0.
   always_ff @(posedge clk) begin
      if (wr_en && wr_addr < 12'd2400) mem[wr_addr] <= wr_data;
      ch_q <= mem[(rd_addr < 12'd2400) ? rd_addr : 12'd0];
      col1_q <= h_q[2:0];
      row1_q <= v_q[3:0];
      row2_q <= row1_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         h_q <= 10'd0;
         v_q <= 10'd0;
         {vis1_q, hs1_q, vs1_q, fs1_q} <= 4'b0110;
         {vis2_q, hs2_q, vs2_q, fs2_q} <= 4'b0110;
         rgb_q <= 12'h000;
         {hs_q, vs_q, fs_q} <= 3'b110;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
         {vis1_q, hs1_q, vs1_q, fs1_q} <= {vis0, hs0, vs0, fs0};
         {vis2_q, hs2_q, vs2_q, fs2_q} <= {vis1_q, hs1_q, vs1_q, fs1_q};
         rgb_q <= rgb_d;
         {hs_q, vs_q, fs_q} <= {hs2_q, vs2_q, fs2_q};
      end
   end
`ifdef CURSOR_EN
   logic [5:0] fc_q;
   logic [6:0] cx1_q, cx2_q;
   logic [4:0] cy1_q, cy2_q;
   always_ff @(posedge clk) begin
      cx1_q <= h_q[9:3];
      cy1_q <= v_q[8:4];
      cx2_q <= cx1_q;
      cy2_q <= cy1_q;
      if (rst) fc_q <= 6'd0;
      else if (h_q == 10'd799 && v_q == 10'd524) fc_q <= fc_q + 6'd1;
   end
   assign cur = !fc_q[5] && (cursor_col < 7'd80) && (cursor_row < 5'd30) &&
                (cx2_q == cursor_col) && (cy2_q == cursor_row) && (row2_q >= 4'd14);
`else
   logic unused_cursor;
   assign unused_cursor = ^{cursor_col, cursor_row, row2_q};
   assign cur = 1'b0;
`endif
   assign font_ascii = ch_q;
   assign font_row = row1_q;
   assign font_col = col1_q;
   assign rgb = rgb_q;
   assign hsync = hs_q;
   assign vsync = vs_q;
   assign frame_start = fs_q;
endmodule
